// File: rtl/dual_port_memory_pkg.sv
// Shared types and helpers for the dual-port memory: clear-sequencer state
// encoding, read-during-write mode constants and the lane-count helper.
package dual_port_memory_pkg;

    // Clear sequencer states: sweeping the array, or open for port traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_e;

    // Values accepted by the READ_FIRST parameter.
    localparam int READ_MODE_WRITE_FIRST = 0;
    localparam int READ_MODE_READ_FIRST  = 1;

    // Number of independently writable lanes in one word.
    function automatic int lane_count(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/dual_port_memory_clear.sv
// Post-reset clear sequencer: walks every address once, emitting a write
// strobe and address for the array, and flags busy until the walk completes.
module dual_port_memory_clear
    import dual_port_memory_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o,
    output logic                  clr_we_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clear_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Next state: advance the sweep counter, leave CLEAR after the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = READY;
            end
        end
    end

    // State register; reset restarts the sweep from address 0 (or skips it).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Busy covers the reset cycles themselves so ports are locked out at once.
    assign busy_o     = rst | (state_q == CLEAR);
    assign clr_we_o   = (state_q == CLEAR) & ~rst;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dual_port_memory.sv
// True dual-port synchronous RAM with per-lane write masks, selectable
// read-during-write behaviour, deterministic collision merging and a
// post-reset clear sweep.
// Optional build macro DPRAM_OUT_REG_EN adds an output register per port
// (read latency 2 instead of 1).
module dual_port_memory
    import dual_port_memory_pkg::*;
#(
    parameter int                  DATA_WIDTH     = 14,
    parameter int                  ADDR_WIDTH     = 6,
    parameter int                  LANE_WIDTH     = 7,
    parameter int                  READ_FIRST     = 0,
    parameter int                  PORT_A_WINS    = 1,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              port1_addr,
    input  logic [ADDR_WIDTH-1:0]              port2_addr,
    input  logic [DATA_WIDTH-1:0]              port1_data_in,
    input  logic [DATA_WIDTH-1:0]              port2_data_in,
    input  logic                               port1_write_en,
    input  logic                               port2_write_en,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   port1_lane_en,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   port2_lane_en,
    output logic [DATA_WIDTH-1:0]              port1_data_out,
    output logic [DATA_WIDTH-1:0]              port2_data_out,
    output logic                               busy,
    output logic                               collision,
    output logic [ADDR_WIDTH-1:0]              collision_addr
);

    localparam int LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  we1_eff, we2_eff, same_addr, col_d;
    logic [DATA_WIDTH-1:0] old1, old2, merged1, merged2;
    logic [DATA_WIDTH-1:0] rd1_q, rd2_q;
    logic                  collision_q;
    logic [ADDR_WIDTH-1:0] collision_addr_q;

    dual_port_memory_clear #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .busy_o     (busy),
        .clr_addr_o (clr_addr),
        .clr_we_o   (clr_we)
    );

    // Port writes are dropped entirely while the sweep owns the array.
    assign we1_eff   = port1_write_en & ~busy;
    assign we2_eff   = port2_write_en & ~busy;
    assign same_addr = (port1_addr == port2_addr);
    assign col_d     = we1_eff & we2_eff & same_addr & (|(port1_lane_en & port2_lane_en));

    assign old1 = mem[port1_addr];
    assign old2 = mem[port2_addr];

    // Post-write word seen at each port's address. When both ports hit the
    // same address the two merges are identical, so the two array writes
    // below never disagree.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int LO = gi * LANE_WIDTH;
            logic a_on1, b_on1, a_on2, b_on2;
            logic [LANE_WIDTH-1:0] d1, d2, win;

            assign d1    = port1_data_in[LO +: LANE_WIDTH];
            assign d2    = port2_data_in[LO +: LANE_WIDTH];
            assign win   = (PORT_A_WINS != 0) ? d1 : d2;
            assign a_on1 = we1_eff & port1_lane_en[gi];
            assign b_on1 = we2_eff & port2_lane_en[gi] & same_addr;
            assign a_on2 = we1_eff & port1_lane_en[gi] & same_addr;
            assign b_on2 = we2_eff & port2_lane_en[gi];

            assign merged1[LO +: LANE_WIDTH] = (a_on1 & b_on1) ? win :
                                               a_on1 ? d1 :
                                               b_on1 ? d2 : old1[LO +: LANE_WIDTH];
            assign merged2[LO +: LANE_WIDTH] = (a_on2 & b_on2) ? win :
                                               a_on2 ? d1 :
                                               b_on2 ? d2 : old2[LO +: LANE_WIDTH];
        end
    endgenerate

    // Array update: sweep write, or the merged words from either port.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end
        if (we1_eff) begin
            mem[port1_addr] <= merged1;
        end
        if (we2_eff) begin
            mem[port2_addr] <= merged2;
        end
    end

    // Read registers: old contents in read-first mode, post-write otherwise.
    always_ff @(posedge clk) begin
        if (busy) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else if (READ_FIRST == READ_MODE_READ_FIRST) begin
            rd1_q <= old1;
            rd2_q <= old2;
        end else begin
            rd1_q <= merged1;
            rd2_q <= merged2;
        end
    end

    // Collision pulse and sticky address of the most recent collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_q      <= 1'b0;
            collision_addr_q <= '0;
        end else begin
            collision_q <= col_d;
            if (col_d) begin
                collision_addr_q <= port1_addr;
            end
        end
    end

    assign collision      = collision_q;
    assign collision_addr = collision_addr_q;

`ifdef DPRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out1_q, out2_q;

    // Extra output stage, also forced to zero during the sweep.
    always_ff @(posedge clk) begin
        if (busy) begin
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            out1_q <= rd1_q;
            out2_q <= rd2_q;
        end
    end

    assign port1_data_out = out1_q;
    assign port2_data_out = out2_q;
`else
    assign port1_data_out = rd1_q;
    assign port2_data_out = rd2_q;
`endif

endmodule

// File: tb/tb_dual_port_memory.sv
// Scoreboard bench for dual_port_memory: stimulus pushes expected values
// tagged with the cycle they are due; a monitor compares them each cycle.
module tb_dual_port_memory;

`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int          RF  = 0;
    localparam int          PAW = 1;
    localparam logic [13:0] CV  = 14'h1555;

    localparam int K_D1 = 0, K_D2 = 1, K_COL = 2, K_CADDR = 3, K_BUSY = 4;

    typedef struct {
        int          due;
        int          kind;
        logic [13:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  port1_addr = '0, port2_addr = '0;
    logic [13:0] port1_data_in = '0, port2_data_in = '0;
    logic        port1_write_en = 1'b0, port2_write_en = 1'b0;
    logic [1:0]  port1_lane_en = '0, port2_lane_en = '0;
    logic [13:0] port1_data_out, port2_data_out;
    logic        busy, collision;
    logic [5:0]  collision_addr;

    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t sb[$];

    dual_port_memory #(
        .DATA_WIDTH     (14),
        .ADDR_WIDTH     (6),
        .LANE_WIDTH     (7),
        .READ_FIRST     (RF),
        .PORT_A_WINS    (PAW),
        .CLEAR_ON_RESET (1),
        .CLEAR_VALUE    (CV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .port1_addr     (port1_addr),
        .port2_addr     (port2_addr),
        .port1_data_in  (port1_data_in),
        .port2_data_in  (port2_data_in),
        .port1_write_en (port1_write_en),
        .port2_write_en (port2_write_en),
        .port1_lane_en  (port1_lane_en),
        .port2_lane_en  (port2_lane_en),
        .port1_data_out (port1_data_out),
        .port2_data_out (port2_data_out),
        .busy           (busy),
        .collision      (collision),
        .collision_addr (collision_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int due, input int kind, input logic [13:0] exp,
                                 input string name);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endfunction

    // Monitor: just after each rising edge, check everything due this cycle.
    initial begin : monitor
        exp_t        keep[$];
        logic [13:0] act;
        forever begin
            @(posedge clk);
            #1;
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].due == cyc) begin
                    case (sb[i].kind)
                        K_D1:    act = port1_data_out;
                        K_D2:    act = port2_data_out;
                        K_COL:   act = {13'b0, collision};
                        K_CADDR: act = {8'b0, collision_addr};
                        default: act = {13'b0, busy};
                    endcase
                    n_total++;
                    if (act !== sb[i].exp) begin
                        n_bad++;
                        $display("FAIL %s cyc=%0d: got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
                    end else begin
                        $display("ok   %s cyc=%0d: %h", sb[i].name, cyc, act);
                    end
                end else if (sb[i].due < cyc) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL %s: check missed (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
                end else begin
                    keep.push_back(sb[i]);
                end
            end
            sb = keep;
        end
    end

    // Pulse reset for one cycle and queue the reset-state and busy expectations.
    task automatic start_reset(input bit full, input int n_busy);
        int d;
        @(negedge clk);
        rst = 1'b1;
        port1_write_en = 1'b0;
        port2_write_en = 1'b0;
        push(cyc + 1, K_D1, 14'h0, "rst.d1");
        push(cyc + 1, K_D2, 14'h0, "rst.d2");
        push(cyc + 1, K_BUSY, 14'h1, "rst.busy");
        push(cyc + 1, K_COL, 14'h0, "rst.col");
        push(cyc + 1, K_CADDR, 14'h0, "rst.caddr");
        @(negedge clk);
        rst = 1'b0;
        d = cyc;
        for (int c = d + 1; c <= d + n_busy; c++) push(c, K_BUSY, 14'h1, "sweep.busy");
        if (full) push(d + 64, K_BUSY, 14'h0, "sweep.done");
    endtask

    // One cycle of port activity; chk bit0=port1 data, bit1=port2 data, bit2=collision.
    task automatic step(input logic [5:0] a1, input logic we1, input logic [1:0] le1,
                        input logic [13:0] w1, input logic [5:0] a2, input logic we2,
                        input logic [1:0] le2, input logic [13:0] w2, input int chk,
                        input logic [13:0] e1, input logic [13:0] e2, input logic ecol,
                        input logic [5:0] eca, input string nm);
        @(negedge clk);
        port1_addr = a1; port1_write_en = we1; port1_lane_en = le1; port1_data_in = w1;
        port2_addr = a2; port2_write_en = we2; port2_lane_en = le2; port2_data_in = w2;
        if (chk[0]) push(cyc + LAT, K_D1, e1, {nm, ".d1"});
        if (chk[1]) push(cyc + LAT, K_D2, e2, {nm, ".d2"});
        if (chk[2]) begin
            push(cyc + 1, K_COL, {13'b0, ecol}, {nm, ".col"});
            push(cyc + 1, K_CADDR, {8'b0, eca}, {nm, ".caddr"});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(6'd0, 1'b0, 2'b00, 14'h0, 6'd0, 1'b0, 2'b00, 14'h0, 0, 14'h0, 14'h0, 1'b0, 6'd0, "idle");
    endtask

    function automatic logic [13:0] rd(input logic [13:0] old_v, input logic [13:0] new_v);
        return (RF != 0) ? old_v : new_v;
    endfunction

    initial begin : stimulus
        logic [13:0] win12, m33, m40;
        win12 = (PAW != 0) ? 14'h0AAA : 14'h1555;
        m33   = (PAW != 0) ? 14'h3F80 : 14'h3FFF;
        m40   = (PAW != 0) ? 14'h0055 : 14'h3FD5;

        repeat (3) @(negedge clk);

        // Sweep aborted by reset after 20 cycles; writes meanwhile are dropped.
        start_reset(1'b0, 20);
        repeat (19) step(6'd3, 1'b1, 2'b11, 14'h0F0F, 6'd40, 1'b1, 2'b11, 14'h0F0F, 7,
                         14'h0, 14'h0, 1'b0, 6'd0, "sweep1.wr");
        // Full sweep, again with writes that must be discarded.
        start_reset(1'b1, 63);
        repeat (60) step(6'd3, 1'b1, 2'b11, 14'h0F0F, 6'd50, 1'b1, 2'b11, 14'h0F0F, 7,
                         14'h0, 14'h0, 1'b0, 6'd0, "sweep2.wr");
        idle(3);

        step(6'd0, 0, 2'b00, 14'h0, 6'd37, 0, 2'b00, 14'h0, 7, CV, CV, 0, 6'd0, "clr.rd0_37");
        step(6'd63, 0, 2'b00, 14'h0, 6'd3, 0, 2'b00, 14'h0, 7, CV, CV, 0, 6'd0, "clr.rd63_3");
        step(6'd5, 1, 2'b11, 14'h0, 6'd9, 1, 2'b11, 14'h0, 7,
             rd(CV, 14'h0), rd(CV, 14'h0), 0, 6'd0, "zero5_9");
        step(6'd5, 1, 2'b01, 14'h3FFF, 6'd5, 0, 2'b00, 14'h0, 7,
             rd(14'h0, 14'h007F), rd(14'h0, 14'h007F), 0, 6'd0, "lane0_wr5");
        step(6'd5, 0, 2'b00, 14'h0, 6'd9, 0, 2'b00, 14'h0, 7, 14'h007F, 14'h0, 0, 6'd0, "rd5_9");
        step(6'd9, 1, 2'b11, 14'h1234, 6'd9, 0, 2'b00, 14'h0, 7,
             rd(14'h0, 14'h1234), rd(14'h0, 14'h1234), 0, 6'd0, "rdw9");
        step(6'd9, 0, 2'b00, 14'h0, 6'd9, 0, 2'b00, 14'h0, 7, 14'h1234, 14'h1234, 0, 6'd0, "rd9");
        step(6'd12, 1, 2'b11, 14'h0AAA, 6'd12, 1, 2'b11, 14'h1555, 7,
             rd(CV, win12), rd(CV, win12), 1, 6'd12, "coll12");
        step(6'd12, 0, 2'b00, 14'h0, 6'd12, 0, 2'b00, 14'h0, 7, win12, win12, 0, 6'd12, "rd12");
        step(6'd20, 1, 2'b01, 14'h0AAA, 6'd20, 1, 2'b10, 14'h1555, 7,
             rd(CV, 14'h152A), rd(CV, 14'h152A), 0, 6'd12, "merge20");
        step(6'd20, 0, 2'b00, 14'h0, 6'd20, 0, 2'b00, 14'h0, 7, 14'h152A, 14'h152A, 0, 6'd12, "rd20");
        step(6'd33, 1, 2'b01, 14'h0, 6'd33, 1, 2'b11, 14'h3FFF, 7,
             rd(CV, m33), rd(CV, m33), 1, 6'd33, "coll33");
        step(6'd33, 0, 2'b00, 14'h0, 6'd33, 0, 2'b00, 14'h0, 7, m33, m33, 0, 6'd33, "rd33");
        step(6'd40, 1, 2'b10, 14'h0, 6'd40, 1, 2'b10, 14'h3FFF, 7,
             rd(CV, m40), rd(CV, m40), 1, 6'd40, "coll40");
        step(6'd41, 1, 2'b10, 14'h0, 6'd41, 1, 2'b10, 14'h3FFF, 7,
             rd(CV, m40), rd(CV, m40), 1, 6'd41, "coll41");
        step(6'd40, 0, 2'b00, 14'h0, 6'd41, 0, 2'b00, 14'h0, 7, m40, m40, 0, 6'd41, "rd40_41");
        step(6'd50, 1, 2'b11, 14'h0123, 6'd51, 1, 2'b11, 14'h0456, 7,
             rd(CV, 14'h0123), rd(CV, 14'h0456), 0, 6'd41, "diffaddr");
        step(6'd51, 0, 2'b00, 14'h0, 6'd50, 0, 2'b00, 14'h0, 7, 14'h0456, 14'h0123, 0, 6'd41, "rd51_50");
        idle(LAT + 3);

        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
